unary_accum_n: RTL

Parametrised N-channel unary accumulator with a serial unary read-out, successor to the 2-input, 2-bit unary adder. Each accepted beat adds the popcount of an N-bit unary input vector into a CNT_W-bit counter, and reports overflow as a carry pulse. After the last beat, the counter value is emitted as a unary pulse train on `dout`, followed by a `done` strobe. It sits between the unary stream sources and the downstream unary serial consumers.

---
 rtl/unary_pkg.sv | 29 ++
 rtl/unary_popcount.sv | 29 ++
 rtl/unary_accum_n.sv | 119 +++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary accumulator.
// Optional saturating mode is selected by the UNARY_ADD_SAT_EN macro in unary_accum_n.
package unary_pkg;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } unary_state_t;

    // Widest vector popcount_f accepts; callers zero-extend narrower vectors.
    localparam int unsigned POP_MAX_W = 64;

    // Beat sum width: one bit wider than the counter so a single wrap is visible.
    function automatic int unsigned sum_width_f(input int unsigned cnt_w);
        return cnt_w + 1;
    endfunction

    // Reference population count over a zero-extended vector.
    function automatic int unsigned popcount_f(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(POP_MAX_W); i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational adder tree counting the set bits of an N_CH-wide unary vector.
module unary_popcount #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned OUT_W = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0]  din,
    output logic [OUT_W-1:0] cnt
);

    localparam int unsigned LVL    = $clog2(N_CH);
    localparam int unsigned LEAVES = 2 ** LVL;

    logic [LEAVES-1:0] din_pad;
    logic [OUT_W-1:0]  node [2*LEAVES-1];

    // Leaves hold single bits (zero padded to a power of two); each parent sums its two children.
    always_comb begin
        din_pad = LEAVES'(din);
        for (int i = 0; i < int'(LEAVES); i++) begin
            node[int'(LEAVES) - 1 + i] = OUT_W'(din_pad[i]);
        end
        for (int i = int'(LEAVES) - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
    end

    assign cnt = node[0];

endmodule

// File: rtl/unary_accum_n.sv
// N-channel unary accumulator with serial unary read-out and done strobe.
// Define UNARY_ADD_SAT_EN for a saturating counter with a sticky sat flag (C then stays 0).
module unary_accum_n
    import unary_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic [N_CH-1:0] din,
    input  logic            din_valid,
    input  logic            din_last,
    output logic            din_ready,
    output logic            dout,
    output logic            C,
    output logic            done,
    output logic            busy
`ifdef UNARY_ADD_SAT_EN
    ,
    output logic            sat
`endif
);

    localparam int unsigned POP_W = $clog2(N_CH + 1);
    localparam int unsigned SUM_W = sum_width_f(CNT_W);

    unary_state_t     state;
    logic [CNT_W-1:0] count;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;
    logic             accept;

    unary_popcount #(
        .N_CH  (N_CH),
        .OUT_W (POP_W)
    ) u_popcount (
        .din (din),
        .cnt (pop)
    );

    // Handshake and status decode straight from state.
    assign din_ready = (state == READ);
    assign busy      = (state != READ);
    assign accept    = en && din_valid && din_ready;
    assign sum       = SUM_W'(pop) + SUM_W'(count);

    // FSM, counter and registered pulse outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= READ;
            count <= '0;
            dout  <= 1'b0;
            C     <= 1'b0;
            done  <= 1'b0;
`ifdef UNARY_ADD_SAT_EN
            sat   <= 1'b0;
`endif
        end else if (clr) begin
            state <= READ;
            count <= '0;
            dout  <= 1'b0;
            C     <= 1'b0;
            done  <= 1'b0;
`ifdef UNARY_ADD_SAT_EN
            sat   <= 1'b0;
`endif
        end else begin
            dout <= 1'b0;
            C    <= 1'b0;
            done <= 1'b0;
            if (en) begin
                case (state)
                    READ: begin
                        if (accept) begin
`ifdef UNARY_ADD_SAT_EN
                            if (sum[CNT_W]) begin
                                count <= '1;
                                sat   <= 1'b1;
                            end else begin
                                count <= sum[CNT_W-1:0];
                            end
`else
                            count <= sum[CNT_W-1:0];
                            C     <= sum[CNT_W];
`endif
                            if (din_last) begin
                                state <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (count != '0) begin
                            dout  <= 1'b1;
                            count <= count - CNT_W'(1);
                        end else begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        count <= '0;
                        state <= READ;
`ifdef UNARY_ADD_SAT_EN
                        sat   <= 1'b0;
`endif
                    end
                    default: begin
                        state <= READ;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
